// File: rtl/fetch_pkg.sv
// fetch_pkg: shared address/word types, the queued fetch entry and fetch constants.
package fetch_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef struct packed {
        addr_t pc;
        word_t instr;
    } fetch_entry_t;
    localparam addr_t INSTR_BYTES  = 32'd4;
    localparam addr_t DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with registered storage; flush beats push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  fetch_entry_t                 push_data_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= inc(wr_q);
            end
            if (pop_i) rd_q <= inc(rd_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC/issue logic in front of a 1-cycle ROM, queueing {pc, instr} for decode.
// Define FETCH_PERF_EN to add handshake and stall performance counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC   = DEF_RESET_PC,
    parameter int    FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    addr_t         pc_q, pc_d, inflight_pc_q;
    logic          inflight_q;
    logic [CW-1:0] count;
    logic [CW:0]   occ_after_pop;
    fetch_entry_t  head;
    logic          pop, push, issue;
    assign imem_addr     = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;
    assign out_valid     = (count != '0) && !redirect_valid;
    assign pop           = out_valid && out_ready;
    assign push          = inflight_q && !redirect_valid;
    // In-flight word counts against capacity so its capture always finds room.
    assign occ_after_pop = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue         = redirect_valid || (occ_after_pop < (CW+1)'(FIFO_DEPTH));
    assign pc_d          = issue ? imem_addr + INSTR_BYTES : pc_q;
    assign out_pc        = out_valid ? head.pc : '0;
    assign out_instr     = out_valid ? head.instr : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= issue;
            inflight_pc_q <= issue ? imem_addr : inflight_pc_q;
        end
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_data_i ('{pc: inflight_pc_q, instr: imem_instr}),
        .head_o      (head),
        .count_o     (count)
    );
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(pop);
            perf_stall_q <= perf_stall_q + 32'(out_valid && !out_ready);
        end
    end
    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus checked against a queue-level fetch model.
module tb_instr_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    logic        clk = 1'b0, rst = 1'b1, redirect_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_pc = '0, imem_addr, imem_instr, out_pc, out_instr;
    logic        out_valid;
    int          checks = 0, failures = 0;
    logic [31:0] m_pc = RST_PC, m_inf_pc = '0;
    bit          m_inf = 1'b0;
    logic [31:0] mq[$];
    int unsigned m_fetch = 0, m_stall = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
    always #5 clk = ~clk;
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction
    always_ff @(posedge clk) imem_instr <= rom(imem_addr);
    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    // One cycle: drive inputs, compare against the model, then advance the model at the edge.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] ea;
        bit          ev, pop, issue;
        int          occ;
        @(negedge clk);
        rst = r;
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
        ea = rv ? {rpc[31:2], 2'b00} : m_pc;
        ev = !rv && mq.size() != 0;
        check("imem_addr", imem_addr, ea);
        check("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            check("out_pc", out_pc, mq[0]);
            check("out_instr", out_instr, rom(mq[0]));
        end
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_stall", perf_stall_cnt, m_stall);
`endif
        @(posedge clk);
        if (r) begin
            m_pc = RST_PC;
            m_inf = 1'b0;
            mq.delete();
            m_fetch = 0;
            m_stall = 0;
        end else begin
            pop = ev && rdy;
            occ = mq.size() + int'(m_inf);
            issue = rv || (occ - int'(pop) < DEPTH);
            if (pop) m_fetch++;
            if (ev && !rdy) m_stall++;
            if (rv) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (m_inf) mq.push_back(m_inf_pc);
            end
            m_inf = issue;
            m_inf_pc = ea;
            if (issue) m_pc = ea + 32'd4;
        end
    endtask
    initial begin
        @(posedge clk);
        step(1, 0, '0, 1);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        for (int i = 0; i < 50 && !(mq.size() != 0 && mq[0] == 32'h10); i++) step(0, 0, '0, 1);
        repeat (5) step(0, 0, '0, 0);
        repeat (10) step(0, 0, '0, 1);
        repeat (3) step(0, 0, '0, 0);
        step(0, 1, 32'h0000_0103, 0);
        repeat (6) step(0, 0, '0, 1);
        step(0, 1, 32'h0000_0200, 1);
        repeat (6) step(0, 0, '0, 1);
        step(0, 1, 32'hFFFF_FFF9, 1);
        repeat (6) step(0, 0, '0, 1);
        repeat (4) step(0, 0, '0, 0);
        step(1, 1, 32'h0000_0400, 1);
        #2;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        repeat (8) step(0, 0, '0, 1);
        for (int i = 0; i < 600; i++)
            step($urandom_range(63) == 0, $urandom_range(9) == 0, $urandom, $urandom_range(2) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
